// File: rtl/pool_pkg.sv
// pool_pkg: shared defaults and encodings for the 2x2 max-pool row stage.
//   DATA_W_DEF    - default sample width (signed two's complement)
//   ROW_PAIRS_DEF - default horizontal-max results per input row
//   OUT_ROWS_DEF  - default pooled output rows per frame
//   ph_t          - row parity: EVEN rows are buffered, ODD rows are pooled
package pool_pkg;

  localparam int unsigned DATA_W_DEF    = 21;
  localparam int unsigned ROW_PAIRS_DEF = 14;
  localparam int unsigned OUT_ROWS_DEF  = 14;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } ph_t;

endpackage

// File: rtl/max2_signed.sv
// max2_signed: combinational signed maximum of two W-bit two's-complement values.
//   a - preferred operand, returned on equality
//   b - second operand
//   y - signed max(a, b)
module max2_signed #(
  parameter int unsigned W = 21
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  // One extra bit keeps the compare overflow-free for any operand pair.
  logic signed [W:0] a_x;
  logic signed [W:0] b_x;

  always_comb begin
    a_x = {a[W-1], a};
    b_x = {b[W-1], b};
    y   = (a_x >= b_x) ? a : b;
  end

endmodule

// File: rtl/pool_row_buffer.sv
// pool_row_buffer: vertical half of a 2x2 max-pool. EVEN rows of horizontal-pair
// maxima are stored in a line buffer; each ODD-row sample is compared with the
// buffered sample of the same column and the signed max is emitted one cycle later.
//   clk          - rising-edge clock
//   rst          - asynchronous active-high reset
//   i_sof        - start of frame, qualifies same-cycle sample as row 0 col 0
//   i_valid      - i_data valid this cycle
//   i_data       - signed horizontal-pair max
//   o_valid      - o_data holds a pooled result this cycle
//   o_data       - signed 2x2 max-pool result (holds when o_valid low)
//   o_frame_done - pulses with the last o_valid of a frame
module pool_row_buffer
  import pool_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned ROW_PAIRS = ROW_PAIRS_DEF,
  parameter int unsigned OUT_ROWS  = OUT_ROWS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sof,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_frame_done
);

  localparam int unsigned COL_W = (ROW_PAIRS > 1) ? $clog2(ROW_PAIRS) : 1;
  localparam int unsigned ROW_W = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(ROW_PAIRS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(OUT_ROWS - 1);

  logic [COL_W-1:0] col_q,     col_d;
  ph_t              ph_q,      ph_d;
  logic [ROW_W-1:0] out_row_q, out_row_d;

  // Position the current sample is processed at (after any i_sof override).
  logic [COL_W-1:0] cur_col;
  ph_t              cur_ph;
  logic [ROW_W-1:0] cur_row;

  logic wr_en;
  logic out_en;
  logic frame_end;

  logic [DATA_W-1:0] line_buf [ROW_PAIRS];
  logic [DATA_W-1:0] buf_rd;
  logic [DATA_W-1:0] max_val;

  // Next-state and control
  always_comb begin
    cur_col   = col_q;
    cur_ph    = ph_q;
    cur_row   = out_row_q;
    if (i_sof) begin
      cur_col = '0;
      cur_ph  = PH_EVEN;
      cur_row = '0;
    end

    col_d     = cur_col;
    ph_d      = cur_ph;
    out_row_d = cur_row;
    wr_en     = 1'b0;
    out_en    = 1'b0;
    frame_end = 1'b0;

    if (i_valid) begin
      wr_en  = (cur_ph == PH_EVEN);
      out_en = (cur_ph == PH_ODD);
      if (cur_col == COL_MAX) begin
        col_d = '0;
        if (cur_ph == PH_EVEN) begin
          ph_d = PH_ODD;
        end else begin
          ph_d = PH_EVEN;
          if (cur_row == ROW_MAX) begin
            out_row_d = '0;
            frame_end = 1'b1;
          end else begin
            out_row_d = cur_row + ROW_W'(1);
          end
        end
      end else begin
        col_d = cur_col + COL_W'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      ph_q         <= PH_EVEN;
      out_row_q    <= '0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_frame_done <= 1'b0;
    end else begin
      col_q        <= col_d;
      ph_q         <= ph_d;
      out_row_q    <= out_row_d;
      o_valid      <= out_en;
      o_frame_done <= frame_end;
      if (out_en) begin
        o_data <= max_val;
      end
    end
  end

  // Line buffer: not reset, every entry is rewritten by an EVEN row before use.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_buf[cur_col] <= i_data;
    end
  end

  assign buf_rd = line_buf[cur_col];

  max2_signed #(
    .W (DATA_W)
  ) u_max (
    .a (i_data),
    .b (buf_rd),
    .y (max_val)
  );

endmodule
